spi_read_seq: RTL and testbench

//  Sequences the bit-bang SPI master for one flash-style read transaction.
//  On start it feeds the master's byte source port in this order: command, address (MSB first),

---
 rtl/spi_read_seq_if.sv | 25 ++
 rtl/spi_read_seq.sv | 189 ++++++++++++++++++
 tb/tb_spi_read_seq.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_read_seq_if.sv
// Byte source/sink link between spi_read_seq and spi_master.
// master: spi_master side; slave: spi_read_seq side.
interface spi_read_seq_if;
  logic [7:0] tx_data;
  logic       tx_empty;
  logic       tx_get;
  logic [7:0] rx_data;
  logic       rx_put;

  modport master (
    input  tx_data,
    input  tx_empty,
    output tx_get,
    output rx_data,
    output rx_put
  );

  modport slave (
    output tx_data,
    output tx_empty,
    input  tx_get,
    input  rx_data,
    input  rx_put
  );
endinterface

// File: rtl/spi_read_seq.sv
// Flash read sequencer: feeds cmd/addr/dummy/fill bytes to spi_master
// and forwards payload rx bytes. Ports: clock, reset, start/addr/len,
// busy/done, data/valid, sif (tx_data/tx_empty/tx_get/rx_data/rx_put).
module spi_read_seq #(
  parameter int         LW    = 8,
  parameter int         AW    = 24,
  parameter logic [7:0] CMD   = 8'h03,
  parameter int         DUMMY = 0,
  parameter logic [7:0] FILL  = 8'hFF
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  input  logic [AW-1:0] addr,
  input  logic [LW-1:0] len,
  output logic          busy,
  output logic          done,
  output logic [7:0]    data,
  output logic          valid,
  spi_read_seq_if.slave sif
);

  localparam int ABYTES = AW / 8;
  localparam int TW     = LW + 3;
  localparam logic [TW-1:0] HDR =
    TW'(1 + ABYTES + DUMMY);
  localparam logic [LW-1:0] ALAST = LW'(ABYTES - 1);
  localparam logic [LW-1:0] DLAST = LW'(DUMMY - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DUMMY,
    ST_DATA,
    ST_DRAIN
  } state_t;

  state_t        state_q, state_n;
  logic [AW-1:0] addr_q;
  logic [AW-1:0] addr_sh;
  logic [LW-1:0] len_q;
  logic [LW-1:0] cnt_q, cnt_n;
  logic [TW-1:0] rx_cnt_q;
  logic [TW-1:0] total_q;
  logic          busy_q;
  logic          done_q, done_n;
  logic          valid_q;
  logic [7:0]    data_q;
  logic [7:0]    tx_data_q, tx_data_n;
  logic          tx_empty_q, tx_empty_n;
  logic          take;
  logic          accept;

  assign take   = sif.tx_get && !tx_empty_q;
  assign accept = (state_q == ST_IDLE) && start
                  && (len != '0);

  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    done_n  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (len != '0) begin
            state_n = ST_CMD;
            cnt_n   = '0;
          end else begin
            done_n = 1'b1;
          end
        end
      end
      ST_CMD: begin
        if (take) begin
          state_n = ST_ADDR;
          cnt_n   = '0;
        end
      end
      ST_ADDR: begin
        if (take) begin
          if (cnt_q == ALAST) begin
            cnt_n   = '0;
            state_n = (DUMMY > 0) ? ST_DUMMY
                                  : ST_DATA;
          end else begin
            cnt_n = cnt_q + 1'b1;
          end
        end
      end
      ST_DUMMY: begin
        if (take) begin
          if (cnt_q == DLAST) begin
            cnt_n   = '0;
            state_n = ST_DATA;
          end else begin
            cnt_n = cnt_q + 1'b1;
          end
        end
      end
      ST_DATA: begin
        if (take) begin
          if (cnt_q == len_q - 1'b1) begin
            cnt_n   = '0;
            state_n = ST_DRAIN;
          end else begin
            cnt_n = cnt_q + 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        // every header and payload byte must be back
        if (rx_cnt_q == total_q) begin
          done_n  = 1'b1;
          state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // tx outputs decoded from the next state so the
  // following byte is ready the cycle after tx_get
  always_comb begin
    tx_data_n  = 8'h00;
    tx_empty_n = 1'b1;
    addr_sh    = addr_q << {cnt_n, 3'b000};
    unique case (state_n)
      ST_CMD: begin
        tx_data_n  = CMD;
        tx_empty_n = 1'b0;
      end
      ST_ADDR: begin
        tx_data_n  = addr_sh[AW-1 -: 8];
        tx_empty_n = 1'b0;
      end
      ST_DUMMY, ST_DATA: begin
        tx_data_n  = FILL;
        tx_empty_n = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      len_q      <= '0;
      rx_cnt_q   <= '0;
      total_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      valid_q    <= 1'b0;
      data_q     <= 8'h00;
      tx_data_q  <= 8'h00;
      tx_empty_q <= 1'b1;
    end else begin
      state_q    <= state_n;
      cnt_q      <= cnt_n;
      done_q     <= done_n;
      busy_q     <= (state_n != ST_IDLE);
      tx_data_q  <= tx_data_n;
      tx_empty_q <= tx_empty_n;
      valid_q    <= 1'b0;
      if (accept) begin
        addr_q   <= addr;
        len_q    <= len;
        total_q  <= HDR + TW'(len);
        rx_cnt_q <= '0;
      end else if (busy_q && sif.rx_put) begin
        rx_cnt_q <= rx_cnt_q + 1'b1;
        if (rx_cnt_q >= HDR && rx_cnt_q < total_q) begin
          valid_q <= 1'b1;
          data_q  <= sif.rx_data;
        end
      end
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign data         = data_q;
  assign valid        = valid_q;
  assign sif.tx_data  = tx_data_q;
  assign sif.tx_empty = tx_empty_q;

endmodule

// File: tb/tb_spi_read_seq.sv
// Bench for spi_read_seq: master model, scoreboard queues,
// vector table plus reset and zero-length sequences.
module tb_spi_read_seq;

  logic        clock = 1'b0;
  logic        reset;
  logic        start0, start1;
  logic [23:0] addr0, addr1;
  logic [7:0]  len0, len1;
  logic        busy0, busy1;
  logic        done0, done1;
  logic        valid0, valid1;
  logic [7:0]  data0, data1;

  always #5 clock = ~clock;

  spi_read_seq_if if0 ();
  spi_read_seq_if if1 ();

  spi_read_seq u0 (
    .clock (clock),
    .reset (reset),
    .start (start0),
    .addr  (addr0),
    .len   (len0),
    .busy  (busy0),
    .done  (done0),
    .data  (data0),
    .valid (valid0),
    .sif   (if0.slave)
  );

  spi_read_seq #(
    .CMD   (8'h0B),
    .DUMMY (1)
  ) u1 (
    .clock (clock),
    .reset (reset),
    .start (start1),
    .addr  (addr1),
    .len   (len1),
    .busy  (busy1),
    .done  (done1),
    .data  (data1),
    .valid (valid1),
    .sif   (if1.slave)
  );

  int tests = 0;
  int fails = 0;
  logic [7:0] exp_tx[$];
  logic [7:0] exp_dat[$];

  typedef struct {
    int          sel;
    logic [23:0] addr;
    logic [7:0]  len;
    bit          loop;
    int          gapmax;
    int          nrun;
    bit          hold;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  function automatic logic g_busy(input int s);
    return s != 0 ? busy1 : busy0;
  endfunction
  function automatic logic g_done(input int s);
    return s != 0 ? done1 : done0;
  endfunction
  function automatic logic g_valid(input int s);
    return s != 0 ? valid1 : valid0;
  endfunction
  function automatic logic [7:0] g_data(input int s);
    return s != 0 ? data1 : data0;
  endfunction
  function automatic logic [7:0] g_txd(input int s);
    return s != 0 ? if1.tx_data : if0.tx_data;
  endfunction
  function automatic logic g_empty(input int s);
    return s != 0 ? if1.tx_empty : if0.tx_empty;
  endfunction

  task automatic set_m(input int s, input logic g,
                       input logic p,
                       input logic [7:0] d);
    if (s != 0) begin
      if1.tx_get  = g;
      if1.rx_put  = p;
      if1.rx_data = d;
    end else begin
      if0.tx_get  = g;
      if0.rx_put  = p;
      if0.rx_data = d;
    end
  endtask

  task automatic set_start(input int s, input logic v,
                           input logic [23:0] a,
                           input logic [7:0] l);
    if (s != 0) begin
      start1 = v;
      addr1  = a;
      len1   = l;
    end else begin
      start0 = v;
      addr0  = a;
      len0   = l;
    end
  endtask

  task automatic run_txn(input vec_t v);
    logic [7:0] cmd;
    logic [7:0] txd;
    logic [7:0] rxb;
    int dm, hh, tt;
    int taken, dones, vals, gap;
    bit glitch;
    cmd    = v.sel != 0 ? 8'h0B : 8'h03;
    dm     = v.sel != 0 ? 1 : 0;
    hh     = 4 + dm;
    tt     = hh + int'(v.len);
    taken  = 0;
    dones  = 0;
    vals   = 0;
    gap    = 0;
    glitch = 1'b0;
    for (int r = 0; r < v.nrun; r++) begin
      exp_tx.push_back(cmd);
      exp_tx.push_back(v.addr[23:16]);
      exp_tx.push_back(v.addr[15:8]);
      exp_tx.push_back(v.addr[7:0]);
      for (int i = 0; i < dm; i++)
        exp_tx.push_back(8'hFF);
      for (int j = 0; j < int'(v.len); j++) begin
        exp_tx.push_back(8'hFF);
        exp_dat.push_back(v.loop ? 8'hFF
                          : 8'(8'hB0 + j));
      end
    end
    set_start(v.sel, 1'b1, v.addr, v.len);
    for (int cyc = 0;
         cyc < 5000 && dones < v.nrun; cyc++) begin
      @(negedge clock);
      if (cyc == 0) begin
        chk("busy_start", 32'(g_busy(v.sel)), 1);
        if (!v.hold)
          set_start(v.sel, 1'b0, v.addr, v.len);
      end
      if (g_valid(v.sel)) begin
        vals++;
        if (exp_dat.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL valid_extra: got %0h expected none",
                   g_data(v.sel));
        end else begin
          chk("rx_data", 32'(g_data(v.sel)),
              32'(exp_dat.pop_front()));
        end
      end
      if (g_done(v.sel)) begin
        dones++;
        chk("tx_before_done", taken, tt);
        taken = 0;
        if (dones == v.nrun)
          set_start(v.sel, 1'b0, v.addr, v.len);
      end
      if (g_empty(v.sel) && taken > 0 && taken < tt)
        glitch = 1'b1;
      if (!g_empty(v.sel) && gap == 0) begin
        txd = g_txd(v.sel);
        if (exp_tx.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL tx_extra: got %0h expected none",
                   txd);
        end else begin
          chk("tx_byte", 32'(txd),
              32'(exp_tx.pop_front()));
        end
        if (v.loop)
          rxb = txd;
        else if (taken < hh)
          rxb = 8'(8'hA0 + taken);
        else
          rxb = 8'(8'hB0 + taken - hh);
        set_m(v.sel, 1'b1, 1'b1, rxb);
        taken++;
        gap = $urandom_range(0, v.gapmax);
      end else begin
        set_m(v.sel, 1'b0, 1'b0, 8'h00);
        if (gap > 0)
          gap--;
      end
    end
    set_m(v.sel, 1'b0, 1'b0, 8'h00);
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      if (g_valid(v.sel))
        vals++;
      if (g_done(v.sel))
        dones++;
    end
    chk("done_cnt", dones, v.nrun);
    chk("valid_cnt", vals, v.nrun * int'(v.len));
    chk("tx_left", exp_tx.size(), 0);
    chk("dat_left", exp_dat.size(), 0);
    chk("no_glitch", 32'(glitch), 0);
    chk("busy_end", 32'(g_busy(v.sel)), 0);
    chk("empty_end", 32'(g_empty(v.sel)), 1);
    exp_tx.delete();
    exp_dat.delete();
  endtask

  task automatic run_len0(input int s);
    @(negedge clock);
    set_start(s, 1'b1, 24'h0A0B0C, 8'd0);
    @(negedge clock);
    set_start(s, 1'b0, 24'h0A0B0C, 8'd0);
    chk("len0_done", 32'(g_done(s)), 1);
    chk("len0_busy", 32'(g_busy(s)), 0);
    chk("len0_empty", 32'(g_empty(s)), 1);
    @(negedge clock);
    chk("len0_done_off", 32'(g_done(s)), 0);
    chk("len0_empty2", 32'(g_empty(s)), 1);
  endtask

  initial begin
    vecs[0] = '{0, 24'h123456, 8'd3, 1'b1, 0, 1, 1'b0};
    vecs[1] = '{0, 24'h0F1E2D, 8'd2, 1'b0, 0, 1, 1'b0};
    vecs[2] = '{1, 24'hAAAAAA, 8'd1, 1'b1, 0, 1, 1'b0};
    vecs[3] = '{0, 24'hABCDEF, 8'd4, 1'b1, 5, 2, 1'b1};
    vecs[4] = '{1, 24'h55AA00, 8'd3, 1'b0, 5, 2, 1'b1};
    vecs[5] = '{0, 24'hFFFFFF, 8'd255, 1'b0, 1, 1, 1'b0};

    reset = 1'b1;
    set_start(0, 1'b0, 24'h0, 8'h0);
    set_start(1, 1'b0, 24'h0, 8'h0);
    set_m(0, 1'b0, 1'b0, 8'h00);
    set_m(1, 1'b0, 1'b0, 8'h00);
    repeat (3) @(negedge clock);
    chk("rst_busy", 32'(busy0), 0);
    chk("rst_done", 32'(done0), 0);
    chk("rst_valid", 32'(valid0), 0);
    chk("rst_data", 32'(data0), 0);
    chk("rst_txd", 32'(if0.tx_data), 0);
    chk("rst_empty", 32'(if0.tx_empty), 1);
    chk("rst_empty1", 32'(if1.tx_empty), 1);
    reset = 1'b0;

    // abort in the middle of the address phase
    @(negedge clock);
    set_start(0, 1'b1, 24'h123456, 8'd3);
    @(negedge clock);
    set_start(0, 1'b0, 24'h123456, 8'd3);
    chk("ab_cmd", 32'(if0.tx_data), 32'h03);
    chk("ab_empty0", 32'(if0.tx_empty), 0);
    set_m(0, 1'b1, 1'b1, 8'h03);
    @(negedge clock);
    chk("ab_a0", 32'(if0.tx_data), 32'h12);
    set_m(0, 1'b1, 1'b1, 8'h12);
    @(negedge clock);
    chk("ab_a1", 32'(if0.tx_data), 32'h34);
    set_m(0, 1'b0, 1'b0, 8'h00);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("ab_empty", 32'(if0.tx_empty), 1);
    chk("ab_busy", 32'(busy0), 0);
    chk("ab_done", 32'(done0), 0);
    chk("ab_valid", 32'(valid0), 0);
    @(negedge clock);
    chk("ab_done2", 32'(done0), 0);
    chk("ab_empty2", 32'(if0.tx_empty), 1);

    for (int i = 0; i < 6; i++)
      run_txn(vecs[i]);

    run_len0(0);
    run_len0(1);

    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule
